// File: rtl/battle_link_pkg.sv
// Shared constants, FSM encoding and B3 field helpers for the battle link receiver.
package battle_link_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] CMD_STATE         = 8'h01;
  localparam logic [7:0] CMD_ATTACK        = 8'h02;

  // B3 packs remaining pokemon in the low bits and the move id above them
  localparam int B3_LIFE_LSB = 0;
  localparam int B3_LIFE_MSB = 2;
  localparam int B3_MOVE_LSB = 3;
  localparam int B3_MOVE_MSB = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_B2   = 3'd2,
    ST_B3   = 3'd3,
    ST_CSUM = 3'd4
  } link_state_t;

  function automatic logic [2:0] b3_life(input logic [7:0] b3);
    return b3[B3_LIFE_MSB:B3_LIFE_LSB];
  endfunction

  function automatic logic [4:0] b3_move(input logic [7:0] b3);
    return b3[B3_MOVE_MSB:B3_MOVE_LSB];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rise_pulse.sv
// Registered rising-edge detector: one pulse per low-to-high transition of sig.
module rise_pulse (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  // Remember last cycle's level so a held-high input only counts once
  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign pulse = sig & ~sig_q;

endmodule

// File: rtl/battle_link_rx.sv
// Battle frame decoder: SYNC, CMD, B2, B3, CSUM from the com_mod receive byte stream.
// Produces opponent HP/life/move plus one-cycle accept/error pulses and a saturating error count.
module battle_link_rx
  import battle_link_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 2_000_000,
  parameter int         CNT_W          = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_received,
  input  logic [7:0] rx_byte,
  output logic [7:0] enemy_hp,
  output logic [2:0] enemy_life,
  output logic [4:0] enemy_move,
  output logic       state_update,
  output logic       attack_strobe,
  output logic       frame_error,
  output logic [7:0] err_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic        byte_event;
  link_state_t state;
  logic [7:0]  cmd_q;
  logic [7:0]  b2_q;
  logic [7:0]  b3_q;
  logic [7:0]  csum_q;
  logic [CNT_W-1:0] idle_cnt;

  rise_pulse u_char_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (char_received),
    .pulse (byte_event)
  );

  // Frame FSM, inter-byte timeout and all registered outputs; a byte event beats a same-cycle expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cmd_q         <= 8'h00;
      b2_q          <= 8'h00;
      b3_q          <= 8'h00;
      csum_q        <= 8'h00;
      idle_cnt      <= '0;
      enemy_hp      <= 8'h00;
      enemy_life    <= 3'd0;
      enemy_move    <= 5'd0;
      state_update  <= 1'b0;
      attack_strobe <= 1'b0;
      frame_error   <= 1'b0;
      err_count     <= 8'h00;
    end else begin
      state_update  <= 1'b0;
      attack_strobe <= 1'b0;
      frame_error   <= 1'b0;

      if (byte_event) begin
        idle_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (rx_byte == SYNC_BYTE) state <= ST_CMD;
          end
          ST_CMD: begin
            if (rx_byte == CMD_STATE || rx_byte == CMD_ATTACK) begin
              cmd_q  <= rx_byte;
              csum_q <= rx_byte;
              state  <= ST_B2;
            end else if (rx_byte == SYNC_BYTE) begin
              state <= ST_CMD;
            end else begin
              frame_error <= 1'b1;
              err_count   <= sat_inc8(err_count);
              state       <= ST_IDLE;
            end
          end
          ST_B2: begin
            b2_q   <= rx_byte;
            csum_q <= csum_q ^ rx_byte;
            state  <= ST_B3;
          end
          ST_B3: begin
            b3_q   <= rx_byte;
            csum_q <= csum_q ^ rx_byte;
            state  <= ST_CSUM;
          end
          ST_CSUM: begin
            if (rx_byte != csum_q) begin
              frame_error <= 1'b1;
              err_count   <= sat_inc8(err_count);
            end else if (cmd_q == CMD_STATE) begin
              enemy_hp     <= b2_q;
              enemy_life   <= b3_life(b3_q);
              enemy_move   <= b3_move(b3_q);
              state_update <= 1'b1;
            end else begin
              enemy_move    <= b3_move(b3_q);
              attack_strobe <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (idle_cnt == TIMEOUT_LAST) begin
          idle_cnt    <= '0;
          frame_error <= 1'b1;
          err_count   <= sat_inc8(err_count);
          state       <= ST_IDLE;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_battle_link_rx.sv
// Scoreboard bench for battle_link_rx: directed frames push expected events, a monitor checks each pulse.
module tb_battle_link_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_received;
  logic [7:0] rx_byte;
  logic [7:0] enemy_hp;
  logic [2:0] enemy_life;
  logic [4:0] enemy_move;
  logic       state_update;
  logic       attack_strobe;
  logic       frame_error;
  logic [7:0] err_count;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] hp;
    logic [2:0] life;
    logic [4:0] move;
    logic [7:0] errc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mHp;
  logic [2:0] mLife;
  logic [4:0] mMove;
  int         mErr;

  always #5 clk = ~clk;

  battle_link_rx #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (100),
    .CNT_W          (21)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .char_received (char_received),
    .rx_byte       (rx_byte),
    .enemy_hp      (enemy_hp),
    .enemy_life    (enemy_life),
    .enemy_move    (enemy_move),
    .state_update  (state_update),
    .attack_strobe (attack_strobe),
    .frame_error   (frame_error),
    .err_count     (err_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pops one expectation per observed pulse and compares every output against it
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if ((32'(state_update) + 32'(attack_strobe) + 32'(frame_error)) > 1)
        checkOutput("pulse_exclusive", {state_update, attack_strobe, frame_error}, 3'b000);
      if (state_update || attack_strobe || frame_error) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pulse", {state_update, attack_strobe, frame_error}, 3'b000);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("pulse_kind", {state_update, attack_strobe, frame_error}, e.kind);
          checkOutput("enemy_hp",   enemy_hp,   e.hp);
          checkOutput("enemy_life", enemy_life, e.life);
          checkOutput("enemy_move", enemy_move, e.move);
          checkOutput("err_count",  err_count,  e.errc);
        end
      end
    end
  end

  task automatic pushExp(input logic [2:0] kind);
    exp_t e;
    e.kind = kind;
    e.hp   = mHp;
    e.life = mLife;
    e.move = mMove;
    e.errc = 8'(mErr);
    expQ.push_back(e);
  endtask

  task automatic expectState(input logic [7:0] hp, input logic [2:0] life, input logic [4:0] move);
    mHp = hp; mLife = life; mMove = move;
    pushExp(3'b100);
  endtask

  task automatic expectAttack(input logic [4:0] move);
    mMove = move;
    pushExp(3'b010);
  endtask

  task automatic expectError();
    if (mErr < 255) mErr++;
    pushExp(3'b001);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int hold = 1);
    @(negedge clk);
    rx_byte       = b;
    char_received = 1'b1;
    repeat (hold) @(negedge clk);
    char_received = 1'b0;
    rx_byte       = 8'h00;
  endtask

  task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input int hold = 1);
    applyStimulus(b0, hold);
    applyStimulus(b1, hold);
    applyStimulus(b2, hold);
    applyStimulus(b3, hold);
    applyStimulus(b4, hold);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", expQ.size(), 0);
      expQ.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic resetModel();
    mHp = 8'h00; mLife = 3'd0; mMove = 5'd0; mErr = 0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_hp"},   enemy_hp,   8'h00);
    checkOutput({tag, "_life"}, enemy_life, 3'd0);
    checkOutput({tag, "_move"}, enemy_move, 5'd0);
    checkOutput({tag, "_errc"}, err_count,  8'h00);
    checkOutput({tag, "_pulses"}, {state_update, attack_strobe, frame_error}, 3'b000);
  endtask

  initial begin
    reset         = 1'b1;
    char_received = 1'b0;
    rx_byte       = 8'h00;
    resetModel();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset");

    $display("[TB] STATE frame");
    expectState(8'h64, 3'd2, 5'd3);
    sendFrame(8'hA5, 8'h01, 8'h64, 8'h1A, 8'h7F);
    waitDrain(20);

    $display("[TB] ATTACK frame");
    expectAttack(5'd5);
    sendFrame(8'hA5, 8'h02, 8'h00, 8'h2B, 8'h29);
    waitDrain(20);

    $display("[TB] bad checksum");
    expectError();
    sendFrame(8'hA5, 8'h01, 8'h64, 8'h1A, 8'h00);
    waitDrain(20);

    $display("[TB] stray byte and resync");
    expectState(8'h10, 3'd1, 5'd1);
    applyStimulus(8'h33);
    sendFrame(8'hA5, 8'hA5, 8'h01, 8'h10, 8'h09);
    applyStimulus(8'h18);
    waitDrain(20);

    $display("[TB] payload bytes equal to sync are data");
    expectState(8'hA5, 3'd5, 5'd20);
    sendFrame(8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01);
    waitDrain(20);

    $display("[TB] inter-byte timeout");
    expectError();
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    waitDrain(150);
    expectState(8'h64, 3'd2, 5'd3);
    sendFrame(8'hA5, 8'h01, 8'h64, 8'h1A, 8'h7F);
    waitDrain(20);

    $display("[TB] long char_received level");
    expectState(8'h20, 3'd4, 5'd1);
    sendFrame(8'hA5, 8'h01, 8'h20, 8'h0C, 8'h2D, 10);
    waitDrain(40);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h64);
    applyStimulus(8'h1A);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    resetModel();
    checkIdleOutputs("midreset");
    applyStimulus(8'h7F);
    repeat (5) @(negedge clk);
    checkIdleOutputs("after_midreset");

    $display("[TB] error count saturation");
    for (int i = 0; i < 300; i++) begin
      expectError();
      applyStimulus(8'hA5);
      applyStimulus(8'h03);
    end
    waitDrain(200);
    checkOutput("err_count_saturated", err_count, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so a stuck run still reports
  initial begin
    #2_000_000;
    checks++;
    errors++;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
